// File: rtl/atm_pkg.sv
// Shared definitions for the ATM display path: converter states, segment
// codes, digit enables and the double-dabble helpers.
package atm_pkg;

   localparam int BAL_W = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_e;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [2:0] AN_UNITS    = 3'b001;
   localparam logic [2:0] AN_TENS     = 3'b010;
   localparam logic [2:0] AN_HUNDREDS = 3'b100;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   // Double-dabble correction applied to one BCD nibble before each shift.
   function automatic logic [3:0] dd_adjust(input logic [3:0] nibble);
      logic [3:0] res_v;
      if (nibble >= 4'd5) begin
         res_v = nibble + 4'd3;
      end else begin
         res_v = nibble;
      end
      return res_v;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: converts the balance only when it
// differs from the last committed value and commits all three digits at once.
module bin2bcd_seq
   import atm_pkg::*;
(
   input  logic             clk,
   input  logic             res,
   input  logic [BAL_W-1:0] bin_i,
   output logic             busy_o,
   output logic [3:0]       hund_o,
   output logic [3:0]       tens_o,
   output logic [3:0]       units_o
);

   conv_state_e      state_q, state_d;
   logic [BAL_W-1:0] shift_q, shift_d;
   logic [BAL_W-1:0] src_q, src_d;
   logic [BAL_W-1:0] last_q, last_d;
   logic [11:0]      bcd_q, bcd_d;
   logic [2:0]       iter_q, iter_d;
   logic             busy_q, busy_d;
   logic [3:0]       hund_q, hund_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       units_q, units_d;
   logic [11:0]      adj_s;

   // Converter state and datapath registers.
   always_ff @(posedge clk) begin
      if (!res) begin
         state_q <= IDLE;
         shift_q <= 7'd0;
         src_q   <= 7'd0;
         last_q  <= 7'd0;
         bcd_q   <= 12'd0;
         iter_q  <= 3'd0;
         busy_q  <= 1'b0;
         hund_q  <= 4'd0;
         tens_q  <= 4'd0;
         units_q <= 4'd0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         src_q   <= src_d;
         last_q  <= last_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         busy_q  <= busy_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   // Next-state logic: one add-3/shift iteration per SHIFT cycle.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      src_d   = src_q;
      last_d  = last_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      units_d = units_q;
      adj_s   = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};
      case (state_q)
         IDLE: begin
            if (bin_i != last_q) begin
               shift_d = bin_i;
               src_d   = bin_i;
               bcd_d   = 12'd0;
               iter_d  = 3'd0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            bcd_d   = {adj_s[10:0], shift_q[BAL_W-1]};
            shift_d = {shift_q[BAL_W-2:0], 1'b0};
            iter_d  = iter_q + 3'd1;
            if (iter_q == 3'd6) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            hund_d  = bcd_q[11:8];
            tens_d  = bcd_q[7:4];
            units_d = bcd_q[3:0];
            last_d  = src_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o  = busy_q;
   assign hund_o  = hund_q;
   assign tens_o  = tens_q;
   assign units_o = units_q;

endmodule

// File: rtl/atm_display_driver.sv
// Three-digit multiplexed seven-segment driver for the ATM balance with
// leading-zero blanking and blinking while a balance limit flag is raised.
module atm_display_driver
   import atm_pkg::*;
#(
   parameter int REFRESH_DIV = 16,
   parameter int BLINK_DIV   = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic [BAL_W-1:0] balance,
   input  logic             max_bal,
   input  logic             min_bal,
   output logic [6:0]       seg,
   output logic [2:0]       an,
   output logic             conv_busy
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

   logic [3:0]    hund_s, tens_s, units_s;
   logic [RW-1:0] ref_q, ref_d;
   logic [1:0]    idx_q, idx_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          blink_q, blink_d;
   logic [6:0]    seg_q, seg_d;
   logic [2:0]    an_q, an_d;
   logic [6:0]    code_s;

   bin2bcd_seq u_conv (
      .clk     (clk),
      .res     (res),
      .bin_i   (balance),
      .busy_o  (conv_busy),
      .hund_o  (hund_s),
      .tens_o  (tens_s),
      .units_o (units_s)
   );

   // Scanner counters and registered display outputs.
   always_ff @(posedge clk) begin
      if (!res) begin
         ref_q   <= '0;
         idx_q   <= 2'd0;
         frame_q <= '0;
         blink_q <= 1'b0;
         seg_q   <= SEG_BLANK;
         an_q    <= 3'b000;
      end else begin
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         blink_q <= blink_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   // Refresh, digit-index and blink-phase sequencing.
   always_comb begin
      ref_d   = ref_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      blink_d = blink_q;
      if (ref_q == REF_LAST) begin
         ref_d = '0;
         if (idx_q == 2'd2) begin
            idx_d = 2'd0;
            if (frame_q == FRM_LAST) begin
               frame_d = '0;
               blink_d = ~blink_q;
            end else begin
               frame_d = frame_q + 1'b1;
            end
         end else begin
            idx_d = idx_q + 2'd1;
         end
      end else begin
         ref_d = ref_q + 1'b1;
      end
   end

   // Digit selection, leading-zero blanking and blink gating.
   always_comb begin
      an_d   = 3'b000;
      code_s = SEG_BLANK;
      case (idx_q)
         2'd0: begin
            an_d   = AN_UNITS;
            code_s = seg_encode(units_s);
         end
         2'd1: begin
            an_d = AN_TENS;
            if ((hund_s == 4'd0) && (tens_s == 4'd0)) begin
               code_s = SEG_BLANK;
            end else begin
               code_s = seg_encode(tens_s);
            end
         end
         2'd2: begin
            an_d = AN_HUNDREDS;
            if (hund_s == 4'd0) begin
               code_s = SEG_BLANK;
            end else begin
               code_s = seg_encode(hund_s);
            end
         end
         default: begin
            an_d   = 3'b000;
            code_s = SEG_BLANK;
         end
      endcase
      if ((max_bal | min_bal) && blink_q) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = code_s;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_atm_display_driver.sv
// Directed self-checking bench for atm_display_driver (REFRESH_DIV=4,
// BLINK_DIV=2: 12-cycle frames, 24-cycle blink phases).
module tb_atm_display_driver;

   localparam int RD = 4;
   localparam int BD = 2;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic [6:0] balance = 7'd0;
   logic       max_bal = 1'b0;
   logic       min_bal = 1'b0;
   logic [6:0] seg;
   logic [2:0] an;
   logic       conv_busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   atm_display_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
      .clk       (clk),
      .res       (res),
      .balance   (balance),
      .max_bal   (max_bal),
      .min_bal   (min_bal),
      .seg       (seg),
      .an        (an),
      .conv_busy (conv_busy)
   );

   function automatic logic [6:0] code(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   // Expected segments for value v while digit enable a is active (no blink).
   function automatic logic [6:0] seg_for(input int v, input logic [2:0] a);
      int h, t, u;
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      case (a)
         3'b001: return code(u);
         3'b010: return (h == 0 && t == 0) ? 7'b0000000 : code(t);
         3'b100: return (h == 0) ? 7'b0000000 : code(h);
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sample n cycles after the edge that sees a new balance; optional
   // mid-conversion change to v2 after sample mid_at.
   task automatic watch_conv(input int n, input int v0, input int v1, input int v2, input int mid_at);
      logic bexp;
      int   vexp;
      for (int i = 0; i < n; i++) begin
         cyc();
         bexp = (i <= 7) || (mid_at >= 0 && i >= 9 && i <= 16);
         if (i < 9) vexp = v0;
         else if (mid_at < 0 || i < 18) vexp = v1;
         else vexp = v2;
         chk($sformatf("busy_%0d_i%0d", v1, i), {31'd0, conv_busy}, {31'd0, bexp});
         chk($sformatf("disp_%0d_i%0d", v1, i), {25'd0, seg}, {25'd0, seg_for(vexp, an)});
         if (i == mid_at) balance = 7'(v2);
      end
   endtask

   task automatic check_digit(input string tag, input logic [2:0] target, input logic [6:0] exp);
      int k = 0;
      while (an !== target && k < 3 * RD + 2) begin
         cyc();
         k++;
      end
      chk({tag, "_an"}, {29'd0, an}, {29'd0, target});
      chk(tag, {25'd0, seg}, {25'd0, exp});
   endtask

   task automatic count_window(input int n, output int zeros, output int an_on);
      zeros = 0;
      an_on = 0;
      for (int i = 0; i < n; i++) begin
         cyc();
         if (seg === 7'b0000000) zeros++;
         if (an !== 3'b000) an_on++;
      end
   endtask

   initial begin
      int z, a, k, dwell;

      // Reset
      cyc();
      cyc();
      chk("rst_seg", {25'd0, seg}, 32'd0);
      chk("rst_an", {29'd0, an}, 32'd0);
      chk("rst_busy", {31'd0, conv_busy}, 32'd0);
      res = 1'b1;
      cyc();
      chk("first_an", {29'd0, an}, 32'd1);
      chk("first_seg", {25'd0, seg}, {25'd0, 7'b1111110});
      check_digit("rst_tens", 3'b010, 7'b0000000);
      check_digit("rst_hund", 3'b100, 7'b0000000);

      // Dwell length of the units digit
      k = 0;
      while (an !== 3'b001 && k < 3 * RD + 2) begin cyc(); k++; end
      dwell = 0;
      while (an === 3'b001 && dwell < 20) begin cyc(); dwell++; end
      chk("dwell", dwell, RD);

      // Balance 42
      balance = 7'd42;
      watch_conv(14, 0, 42, 0, -1);
      check_digit("b42_units", 3'b001, 7'b1101101);
      check_digit("b42_tens", 3'b010, 7'b0110011);
      check_digit("b42_hund", 3'b100, 7'b0000000);

      // Zero in the middle
      balance = 7'd100;
      watch_conv(14, 42, 100, 0, -1);
      check_digit("b100_hund", 3'b100, 7'b0110000);
      check_digit("b100_tens", 3'b010, 7'b1111110);
      check_digit("b100_units", 3'b001, 7'b1111110);

      // Change mid-conversion: 42 commits first, then 105
      balance = 7'd42;
      watch_conv(24, 100, 42, 105, 2);
      check_digit("b105_hund", 3'b100, 7'b0110000);
      check_digit("b105_tens", 3'b010, 7'b1111110);
      check_digit("b105_units", 3'b001, 7'b1011011);

      // Maximum balance and blinking
      balance = 7'd127;
      watch_conv(14, 105, 127, 0, -1);
      check_digit("b127_hund", 3'b100, 7'b0110000);
      check_digit("b127_tens", 3'b010, 7'b1101101);
      check_digit("b127_units", 3'b001, 7'b1110000);
      max_bal = 1'b1;
      count_window(48, z, a);
      chk("max_blink_zeros", z, 24);
      chk("max_blink_an", a, 48);
      max_bal = 1'b0;
      min_bal = 1'b1;
      count_window(48, z, a);
      chk("min_blink_zeros", z, 24);
      chk("min_blink_an", a, 48);
      min_bal = 1'b0;
      count_window(48, z, a);
      chk("noflag_zeros", z, 0);

      // Reset during SHIFT
      balance = 7'd42;
      cyc();
      cyc();
      cyc();
      chk("pre_rst_busy", {31'd0, conv_busy}, 32'd1);
      res = 1'b0;
      cyc();
      cyc();
      chk("mid_rst_seg", {25'd0, seg}, 32'd0);
      chk("mid_rst_an", {29'd0, an}, 32'd0);
      chk("mid_rst_busy", {31'd0, conv_busy}, 32'd0);
      res = 1'b1;
      watch_conv(14, 0, 42, 0, -1);
      check_digit("rst42_units", 3'b001, 7'b1101101);
      check_digit("rst42_tens", 3'b010, 7'b0110011);
      check_digit("rst42_hund", 3'b100, 7'b0000000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
